user_la_checkpoint: RTL and testbench

//   User-project-area block: a 32-bit counter driven through the logic analyzer (LA) bus.

---
 rtl/user_la_pkg.sv | 23 ++
 rtl/la_masked_counter.sv | 47 ++++
 rtl/user_la_checkpoint.sv | 95 +++++++++
 tb/tb_user_la_checkpoint.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/user_la_pkg.sv
// Package: user_la_pkg
// Shared constants and helpers for the LA-driven checkpoint counter block.
//   PHASE_ARMED / PHASE_MATCH : phase nibble of the checkpoint word
//   LA_EN_BIT / LA_CLR_BIT    : LA bit positions of the count enable and count clear controls
//   SIGNATURE_DEFAULT         : default constant upper byte of the checkpoint word
package user_la_pkg;

    localparam logic [3:0]  PHASE_ARMED       = 4'h4;
    localparam logic [3:0]  PHASE_MATCH       = 4'h5;

    localparam int unsigned LA_EN_BIT         = 32;
    localparam int unsigned LA_CLR_BIT        = 33;

    localparam logic [7:0]  SIGNATURE_DEFAULT = 8'hAB;

    // Checkpoint word layout: {signature, phase, 3'b000, load_seen}
    function automatic logic [15:0] checkpoint_word(input logic [7:0] sig,
                                                    input logic [3:0] phase,
                                                    input logic       load_seen);
        return {sig, phase, 3'b000, load_seen};
    endfunction

endpackage

// File: rtl/la_masked_counter.sv
// Module: la_masked_counter
// 32-bit counter with clear / masked load / enable priority; wraps at 32'hFFFF_FFFF.
// Ports:
//   i_clk      in   1   clock, rising edge
//   i_rst_n    in   1   synchronous active-low reset
//   i_clr      in   1   clear count (highest priority)
//   i_load     in   1   masked load (no increment in that cycle)
//   i_ld_mask  in  32   bits of the count replaced on load
//   i_ld_data  in  32   load data
//   i_en       in   1   increment enable (lowest priority)
//   o_count    out 32   registered count
module la_masked_counter (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_load,
    input  logic [31:0] i_ld_mask,
    input  logic [31:0] i_ld_data,
    input  logic        i_en,
    output logic [31:0] o_count
);

    logic [31:0] r_count;
    logic [31:0] w_count_d;

    always_comb begin
        w_count_d = r_count;
        if (i_clr) begin
            w_count_d = '0;
        end else if (i_load) begin
            w_count_d = (r_count & ~i_ld_mask) | (i_ld_data & i_ld_mask);
        end else if (i_en) begin
            w_count_d = r_count + 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_d;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/user_la_checkpoint.sv
// Module: user_la_checkpoint
// User-project-area block: a 32-bit counter controlled through the logic analyzer bus that
// publishes a checkpoint word on mprj_io[31:16] (AB40 armed, AB41 load seen, AB51 match).
// Optional feature macro: LA_READBACK_EN -- when defined, la_data_out[63:32] = {16'h0, io_out};
// otherwise la_data_out[63:32] = 0.
// Ports:
//   clock        in   1   system clock, rising edge
//   resetb       in   1   synchronous active-low reset
//   la_data_in   in  64   [31:0] load data, [32] count enable, [33] count clear
//   la_oenb      in  64   0 = management core drives the bit; [31:0] are the load mask
//   la_data_out  out 64   [31:0] count, [63:32] status readback
//   io_out       out 16   checkpoint word
//   io_oeb       out 16   pad output enables, active-low
module user_la_checkpoint
    import user_la_pkg::*;
#(
    parameter logic [31:0] MATCH_VALUE = 32'h0000_0100,
    parameter logic [7:0]  SIGNATURE   = SIGNATURE_DEFAULT
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic [63:0] la_data_in,
    input  logic [63:0] la_oenb,
    output logic [63:0] la_data_out,
    output logic [15:0] io_out,
    output logic [15:0] io_oeb
);

    logic [31:0] w_ld_mask;
    logic        w_load;
    logic        w_clr;
    logic        w_en;
    logic [31:0] w_count;
    logic        w_load_seen_d;
    logic        w_match_seen_d;
    logic [3:0]  w_phase_d;

    logic        r_load_seen;
    logic        r_match_seen;
    logic [15:0] r_io_out;
    logic [15:0] r_io_oeb;

    // Upper LA bits carry no function in this block.
    logic        w_unused_la;
    assign w_unused_la = ^{la_data_in[63:34], la_oenb[63:34]};

    assign w_ld_mask = ~la_oenb[31:0];
    assign w_load    = |w_ld_mask;
    assign w_clr     = ~la_oenb[LA_CLR_BIT] & la_data_in[LA_CLR_BIT];
    // Free-run unless the management core drives the enable bit.
    assign w_en      = la_oenb[LA_EN_BIT] ? 1'b1 : la_data_in[LA_EN_BIT];

    la_masked_counter u_counter (
        .i_clk     (clock),
        .i_rst_n   (resetb),
        .i_clr     (w_clr),
        .i_load    (w_load),
        .i_ld_mask (w_ld_mask),
        .i_ld_data (la_data_in[31:0]),
        .i_en      (w_en),
        .o_count   (w_count)
    );

    // Match only counts once a load has been registered, so AB51 never precedes AB41.
    always_comb begin
        w_load_seen_d  = r_load_seen | w_load;
        w_match_seen_d = r_match_seen | (r_load_seen & (w_count == MATCH_VALUE));
        w_phase_d      = w_match_seen_d ? PHASE_MATCH : PHASE_ARMED;
    end

    // io_out is built from the next-state flags so it updates on the same edge as the flags.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            r_load_seen  <= 1'b0;
            r_match_seen <= 1'b0;
            r_io_out     <= checkpoint_word(SIGNATURE, PHASE_ARMED, 1'b0);
            r_io_oeb     <= 16'hFFFF;
        end else begin
            r_load_seen  <= w_load_seen_d;
            r_match_seen <= w_match_seen_d;
            r_io_out     <= checkpoint_word(SIGNATURE, w_phase_d, w_load_seen_d);
            r_io_oeb     <= 16'h0000;
        end
    end

    assign io_out = r_io_out;
    assign io_oeb = r_io_oeb;

`ifdef LA_READBACK_EN
    assign la_data_out = {16'h0000, r_io_out, w_count};
`else
    assign la_data_out = {32'h0000_0000, w_count};
`endif

endmodule

// File: tb/tb_user_la_checkpoint.sv
// Testbench for user_la_checkpoint: directed stimulus pushes cycle-tagged expectations into a
// scoreboard queue; a monitor on the falling edge pops and compares them.
module tb_user_la_checkpoint;

    logic        clock;
    logic        resetb;
    logic [63:0] la_data_in;
    logic [63:0] la_oenb;
    logic [63:0] la_data_out;
    logic [15:0] io_out;
    logic [15:0] io_oeb;

    user_la_checkpoint dut (
        .clock       (clock),
        .resetb      (resetb),
        .la_data_in  (la_data_in),
        .la_oenb     (la_oenb),
        .la_data_out (la_data_out),
        .io_out      (io_out),
        .io_oeb      (io_oeb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    localparam int K_COUNT = 0;
    localparam int K_IO    = 1;
    localparam int K_OEB   = 2;
    localparam int K_HI    = 3;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
        int          cyc;
    } item_t;

    item_t q[$];
    int    n_total = 0;
    int    n_bad   = 0;

`ifdef LA_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    task automatic expect_val(input string name, input int kind, input logic [31:0] exp);
        item_t it;
        it.name = name;
        it.kind = kind;
        it.exp  = exp;
        it.cyc  = cyc;
        q.push_back(it);
    endtask

    // Expected status word given the expected checkpoint.
    function automatic logic [31:0] hi_of(input logic [15:0] cp);
        return READBACK ? {16'h0000, cp} : 32'h0;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Monitor: compare every expectation tagged for the current cycle.
    always @(negedge clock) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            item_t       it;
            logic [31:0] act;
            it = q.pop_front();
            case (it.kind)
                K_COUNT: act = la_data_out[31:0];
                K_IO:    act = {16'h0, io_out};
                K_OEB:   act = {16'h0, io_oeb};
                default: act = la_data_out[63:32];
            endcase
            n_total++;
            if (it.cyc != cyc) begin
                n_bad++;
                $display("FAIL %s: checked late at cycle %0d, tagged %0d", it.name, cyc, it.cyc);
            end else if (act !== it.exp) begin
                n_bad++;
                $display("FAIL %s: got %08h expected %08h", it.name, act, it.exp);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        resetb     = 1'b0;
        la_oenb    = '1;
        la_data_in = '0;

        // 1. reset held 4 cycles
        step(4);
        expect_val("rst_count", K_COUNT, 32'h0);
        expect_val("rst_oeb",   K_OEB,   32'hFFFF);
        resetb = 1'b1;
        step(1);
        expect_val("rel_io",    K_IO,    32'hAB40);
        expect_val("rel_oeb",   K_OEB,   32'h0000);
        expect_val("rel_count", K_COUNT, 32'h1);
        expect_val("rel_hi",    K_HI,    hi_of(16'hAB40));

        // 3. free-run past MATCH_VALUE with no load
        step(299);
        expect_val("free_count", K_COUNT, 32'd300);
        expect_val("free_io",    K_IO,    32'hAB40);

        // 2. load 0xF0, then free-run to the match
        la_oenb[31:0]    = 32'h0;
        la_data_in[31:0] = 32'hF0;
        step(1);
        expect_val("ld_count", K_COUNT, 32'hF0);
        expect_val("ld_io",    K_IO,    32'hAB41);
        la_oenb[31:0] = 32'hFFFF_FFFF;
        step(15);
        expect_val("pre_count", K_COUNT, 32'hFF);
        step(1);
        expect_val("at_count", K_COUNT, 32'h100);
        expect_val("at_io",    K_IO,    32'hAB41);
        step(1);
        expect_val("m_count", K_COUNT, 32'h101);
        expect_val("m_io",    K_IO,    32'hAB51);
        expect_val("m_hi",    K_HI,    hi_of(16'hAB51));
        step(20);
        expect_val("m_sticky", K_IO, 32'hAB51);

        // 6. reset while at AB51
        resetb = 1'b0;
        step(1);
        expect_val("mr_count", K_COUNT, 32'h0);
        expect_val("mr_oeb",   K_OEB,   32'hFFFF);
        resetb = 1'b1;
        step(1);
        expect_val("mr_io",  K_IO, 32'hAB40);
        expect_val("mr_hi",  K_HI, hi_of(16'hAB40));

        // 4. clear and load in the same cycle, enable under LA control
        la_oenb[33:32]    = 2'b00;
        la_data_in[33:32] = 2'b11;
        la_oenb[31:0]     = 32'h0;
        la_data_in[31:0]  = 32'h1234;
        step(1);
        expect_val("clr_count", K_COUNT, 32'h0);
        expect_val("clr_io",    K_IO,    32'hAB41);
        la_data_in[33:32] = 2'b00;
        la_data_in[31:0]  = 32'h55;
        step(1);
        expect_val("ld55_count", K_COUNT, 32'h55);
        la_oenb[31:0] = 32'hFFFF_FFFF;
        step(3);
        expect_val("hold_count", K_COUNT, 32'h55);
        la_data_in[32] = 1'b1;
        step(2);
        expect_val("en_count", K_COUNT, 32'h57);

        // 5. wrap and partial-mask load
        la_oenb[31:0]    = 32'h0;
        la_data_in[31:0] = 32'hFFFF_FFFF;
        step(1);
        expect_val("ldff_count", K_COUNT, 32'hFFFF_FFFF);
        la_oenb[31:0] = 32'hFFFF_FFFF;
        step(1);
        expect_val("wrap_count", K_COUNT, 32'h0);
        la_oenb[31:0]    = 32'h0;
        la_data_in[31:0] = 32'h1234_5678;
        step(1);
        expect_val("ldfull_count", K_COUNT, 32'h1234_5678);
        la_oenb[31:0]    = 32'hFFFF_FF00;
        la_data_in[31:0] = 32'hAAAA_AA3C;
        step(1);
        expect_val("part_count", K_COUNT, 32'h1234_563C);
        la_oenb[31:0] = 32'hFFFF_FFFF;
        step(1);
        expect_val("post_count", K_COUNT, 32'h1234_563D);
        expect_val("post_io",    K_IO,    32'hAB41);

        step(3);
        while (q.size() > 0) begin
            item_t it;
            it = q.pop_front();
            n_total++;
            n_bad++;
            $display("FAIL %s: never checked, expected %08h", it.name, it.exp);
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
